// File: rtl/adder_arb_pkg.sv
// Shared constants and types for adder_share_arbiter: default sizing, tag width helper,
// tag-pipe entry layout and grant-counter width.
package adder_arb_pkg;

    localparam int unsigned N_DEF   = 4;
    localparam int unsigned W_DEF   = 128;
    localparam int unsigned LAT_DEF = 4;
    localparam int unsigned CNT_W   = 16;

    // Tags are stored at a fixed width so the entry type stays valid for any N up to 256.
    localparam int unsigned TW_MAX  = 8;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned TW_DEF  = tag_width(N_DEF);

    typedef struct packed {
        logic              vld;
        logic [TW_MAX-1:0] tag;
    } tag_ent_t;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Grants are suppressed while en is low or reset is asserted.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = tag_width(N);

    logic [PW-1:0] ptr_q, ptr_d;
    int            idx;

    // Scan from the farthest candidate to the nearest so the nearest set request wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = 0;
        if (rstn && en) begin
            for (int k = int'(N); k >= 1; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= int'(N)) begin
                    idx = idx - int'(N);
                end
                for (int i = 0; i < int'(N); i++) begin
                    if (i == idx && req[i]) begin
                        gnt    = '0;
                        gnt[i] = 1'b1;
                        ptr_d  = PW'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one LAT-cycle pipelined adder among N requesters with round-robin issue and
// tagged result return. Define ADDER_ARB_STATS_EN to build per-requester grant counters.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned W   = W_DEF,
    parameter int unsigned LAT = LAT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_op1,
    input  logic [N*W-1:0]   req_op2,
    input  logic [N-1:0]     req_cin,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     add_op1,
    output logic [W-1:0]     add_op2,
    output logic             add_cin,
    output logic             add_vld,
    input  logic [W-1:0]     add_res,
    input  logic             add_res_vld,
    output logic [N-1:0]     rsp_vld,
    output logic [W-1:0]     rsp_data,
    output logic             err,
    output logic [N*CNT_W-1:0] stats
);

    logic              accept;
    logic [W-1:0]      sel_op1, sel_op2;
    logic              sel_cin;
    logic [TW_MAX-1:0] sel_tag, iss_tag;
    tag_ent_t          tag_pipe [LAT];
    tag_ent_t          pipe_out;
    logic              rsp_hit;
    logic [N-1:0]      rsp_sel;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .req  (req),
        .gnt  (gnt)
    );

    always_comb begin
        accept  = |gnt;
        sel_op1 = '0;
        sel_op2 = '0;
        sel_cin = 1'b0;
        sel_tag = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt[i]) begin
                sel_op1 = req_op1[i*W +: W];
                sel_op2 = req_op2[i*W +: W];
                sel_cin = req_cin[i];
                sel_tag = TW_MAX'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            add_vld <= 1'b0;
            add_op1 <= '0;
            add_op2 <= '0;
            add_cin <= 1'b0;
            iss_tag <= '0;
        end else begin
            add_vld <= accept;
            if (accept) begin
                add_op1 <= sel_op1;
                add_op2 <= sel_op2;
                add_cin <= sel_cin;
                iss_tag <= sel_tag;
            end
        end
    end

    // Entry 0 samples the issue register, mirroring the adder's first stage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(LAT); i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{vld: add_vld, tag: iss_tag};
            for (int i = 1; i < int'(LAT); i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        pipe_out = tag_pipe[LAT-1];
        rsp_hit  = add_res_vld & pipe_out.vld;
        rsp_sel  = '0;
        for (int i = 0; i < int'(N); i++) begin
            rsp_sel[i] = rsp_hit && (pipe_out.tag == TW_MAX'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_vld  <= '0;
            rsp_data <= '0;
            err      <= 1'b0;
        end else begin
            rsp_vld <= rsp_sel;
            if (rsp_hit) begin
                rsp_data <= add_res;
            end
            if (add_res_vld != pipe_out.vld) begin
                err <= 1'b1;
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (gnt[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stats = '0;
        for (int i = 0; i < int'(N); i++) begin
            stats[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    assign stats = '0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: pipelined adder model plus a queue-based
// reference of grant order and response timing.
module tb_adder_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 128;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_op1;
    logic [N*W-1:0]   req_op2;
    logic [N-1:0]     req_cin;
    logic [N-1:0]     gnt;
    logic [W-1:0]     add_op1, add_op2;
    logic             add_cin, add_vld;
    logic [W-1:0]     add_res;
    logic             add_res_vld;
    logic [N-1:0]     rsp_vld;
    logic [W-1:0]     rsp_data;
    logic             err;
    logic [N*16-1:0]  stats;

    always #5 clk = ~clk;

    adder_share_arbiter #(
        .N   (N),
        .W   (W),
        .LAT (LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .req         (req),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_cin     (req_cin),
        .gnt         (gnt),
        .add_op1     (add_op1),
        .add_op2     (add_op2),
        .add_cin     (add_cin),
        .add_vld     (add_vld),
        .add_res     (add_res),
        .add_res_vld (add_res_vld),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .err         (err),
        .stats       (stats)
    );

    // Pipelined adder, reset together with the DUT; inj_vld forces a spurious result valid.
    logic [W-1:0] a_sum [LAT];
    logic         a_vld [LAT];
    logic         inj_vld = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                a_vld[i] <= 1'b0;
                a_sum[i] <= '0;
            end
        end else begin
            a_vld[0] <= add_vld;
            a_sum[0] <= add_op1 + add_op2 + W'(add_cin);
            for (int i = 1; i < LAT; i++) begin
                a_vld[i] <= a_vld[i-1];
                a_sum[i] <= a_sum[i-1];
            end
        end
    end

    assign add_res     = a_sum[LAT-1];
    assign add_res_vld = a_vld[LAT-1] | inj_vld;

    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] sum;
    } exp_t;

    exp_t         q[$];
    int           cyc;
    int           mptr;
    int unsigned  mstats [N];
    logic [N-1:0] gnt_seen, gnt_exp, rsp_exp_vld;
    logic [W-1:0] rsp_exp_data;
    logic         err_exp;
    int           checks;
    int           errors;

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_op1[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
            req_op2[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
        end
        req_cin = N'($urandom);
    endtask

    // One clock: sample gnt before the edge, advance the reference model, return at edge+1.
    task automatic tick();
        int   g;
        int   idx;
        exp_t e;
        #3;
        gnt_seen = gnt;
        gnt_exp  = '0;
        g        = -1;
        if (rstn && en) begin
            for (int k = 1; k <= N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && req[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            gnt_exp = N'(1) << g;
            mptr    = g;
            e.due   = cyc + LAT + 2;
            e.idx   = g;
            e.sum   = req_op1[g*W +: W] + req_op2[g*W +: W] + W'(req_cin[g]);
            q.push_back(e);
            if (mstats[g] < 65535) mstats[g]++;
        end
        if (!rstn) begin
            mptr = N - 1;
            q.delete();
            err_exp      = 1'b0;
            rsp_exp_data = '0;
            for (int i = 0; i < N; i++) mstats[i] = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        rsp_exp_vld = '0;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due == cyc) begin
                rsp_exp_vld[e.idx] = 1'b1;
                rsp_exp_data       = e.sum;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en   = 1'b0;
        req  = '0;
        rand_ops();
        tick();
        en  = 1'b1;
        req = '1;
        tick();
        checks++; if (gnt_seen !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt_seen); end
        checks++; if (add_vld !== 1'b0) begin errors++; $display("FAIL reset_add_vld: got %b expected 0", add_vld); end
        checks++; if (add_op1 !== '0) begin errors++; $display("FAIL reset_add_op1: got %h expected 0", add_op1); end
        checks++; if (rsp_vld !== '0) begin errors++; $display("FAIL reset_rsp_vld: got %b expected 0", rsp_vld); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (stats !== '0) begin errors++; $display("FAIL reset_stats: got %h expected 0", stats); end
        req  = '0;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        rand_ops();
        en  = 1'b1;
        req = 4'b0100;
        req_op1[2*W +: W] = W'(5);
        req_op2[2*W +: W] = W'(7);
        req_cin[2] = 1'b1;
        tick();
        checks++; if (gnt_seen !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt_seen); end
        checks++; if (add_vld !== 1'b1 || add_op1 !== W'(5) || add_op2 !== W'(7) || add_cin !== 1'b1) begin
            errors++; $display("FAIL single_issue: got vld=%b op1=%0d op2=%0d cin=%b expected 1 5 7 1",
                                add_vld, add_op1, add_op2, add_cin);
        end
        req = '0;
        for (int t = 1; t <= LAT + 3; t++) begin
            tick();
            checks++; if (gnt_seen !== '0) begin errors++; $display("FAIL single_gnt_once: got %b expected 0", gnt_seen); end
            if (t == LAT + 1) begin
                checks++; if (rsp_vld !== 4'b0100 || rsp_data !== W'(13)) begin
                    errors++; $display("FAIL single_rsp: got vld=%b data=%0d expected 0100 13", rsp_vld, rsp_data);
                end
            end else begin
                checks++; if (rsp_vld !== '0) begin errors++; $display("FAIL single_rsp_idle: got %b expected 0 (t=%0d)", rsp_vld, t); end
            end
        end
    endtask

    task automatic test_all_four();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        en   = 1'b1;
        req  = 4'hF;
        for (int c = 0; c < 8 + LAT + 3; c++) begin
            if (c == 8) req = '0;
            rand_ops();
            tick();
            if (c < 8) begin
                checks++; if (gnt_seen !== (N'(1) << (c % N))) begin
                    errors++; $display("FAIL rr_order: got %b expected %b (c=%0d)", gnt_seen, N'(1) << (c % N), c);
                end
            end
            checks++; if (rsp_vld !== rsp_exp_vld) begin errors++; $display("FAIL rr_rsp_vld: got %b expected %b", rsp_vld, rsp_exp_vld); end
            if (rsp_exp_vld != '0) begin
                checks++; if (rsp_data !== rsp_exp_data) begin errors++; $display("FAIL rr_rsp_data: got %h expected %h", rsp_data, rsp_exp_data); end
            end
        end
    endtask

    task automatic test_en_low();
        int seen;
        seen = 0;
        en   = 1'b1;
        req  = 4'hF;
        for (int c = 0; c < 2; c++) begin
            rand_ops();
            tick();
            checks++; if (gnt_seen !== gnt_exp) begin errors++; $display("FAIL enlow_issue_gnt: got %b expected %b", gnt_seen, gnt_exp); end
        end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (gnt_seen !== '0 || add_vld !== 1'b0) begin
                errors++; $display("FAIL enlow_hold: got gnt=%b add_vld=%b expected 0 0", gnt_seen, add_vld);
            end
            checks++; if (rsp_vld !== rsp_exp_vld) begin errors++; $display("FAIL enlow_rsp_vld: got %b expected %b", rsp_vld, rsp_exp_vld); end
            if (rsp_exp_vld != '0) begin
                checks++; if (rsp_data !== rsp_exp_data) begin errors++; $display("FAIL enlow_rsp_data: got %h expected %h", rsp_data, rsp_exp_data); end
            end
            if (rsp_vld != '0) seen++;
        end
        checks++; if (seen !== 2) begin errors++; $display("FAIL enlow_inflight: got %0d responses expected 2", seen); end
        en = 1'b1;
        tick();
        checks++; if (gnt_seen !== gnt_exp) begin errors++; $display("FAIL enlow_resume: got %b expected %b", gnt_seen, gnt_exp); end
        req = '0;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            checks++; if (rsp_vld !== rsp_exp_vld) begin errors++; $display("FAIL enlow_drain: got %b expected %b", rsp_vld, rsp_exp_vld); end
        end
    endtask

    task automatic test_err();
        req     = '0;
        inj_vld = 1'b1;
        tick();
        inj_vld = 1'b0;
        err_exp = 1'b1;
        checks++; if (rsp_vld !== '0) begin errors++; $display("FAIL err_no_rsp: got %b expected 0", rsp_vld); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (err !== err_exp) begin errors++; $display("FAIL err_sticky: got %b expected %b", err, err_exp); end
            tick();
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (err !== err_exp) begin errors++; $display("FAIL err_clear: got %b expected %b", err, err_exp); end
    endtask

    task automatic test_reset_mid();
        en  = 1'b1;
        req = 4'hF;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            tick();
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req  = '0;
        checks++; if (gnt_seen !== '0) begin errors++; $display("FAIL mid_gnt: got %b expected 0", gnt_seen); end
        checks++; if (add_vld !== 1'b0 || add_op1 !== '0 || rsp_vld !== '0 || rsp_data !== '0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_clear: got add_vld=%b op1=%h rsp_vld=%b rsp_data=%h err=%b expected all 0",
                                add_vld, add_op1, rsp_vld, rsp_data, err);
        end
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            checks++; if (rsp_vld !== '0 || err !== 1'b0) begin
                errors++; $display("FAIL mid_stale: got rsp_vld=%b err=%b expected 0 0", rsp_vld, err);
            end
        end
        req = 4'hF;
        tick();
        req = '0;
        checks++; if (gnt_seen !== 4'b0001) begin errors++; $display("FAIL mid_first_gnt: got %b expected 0001", gnt_seen); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400 + LAT + 3; c++) begin
            en  = ($urandom_range(0, 7) != 0);
            req = (c < 400) ? N'($urandom) : '0;
            rand_ops();
            tick();
            checks++; if (gnt_seen !== gnt_exp) begin errors++; $display("FAIL rand_gnt: got %b expected %b", gnt_seen, gnt_exp); end
            checks++; if (rsp_vld !== rsp_exp_vld) begin errors++; $display("FAIL rand_rsp_vld: got %b expected %b", rsp_vld, rsp_exp_vld); end
            if (rsp_exp_vld != '0) begin
                checks++; if (rsp_data !== rsp_exp_data) begin errors++; $display("FAIL rand_rsp_data: got %h expected %h", rsp_data, rsp_exp_data); end
            end
            checks++; if (err !== err_exp) begin errors++; $display("FAIL rand_err: got %b expected %b", err, err_exp); end
        end
    endtask

`ifdef ADDER_ARB_STATS_EN
    task automatic test_stats();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        en   = 1'b1;
        req  = 4'b0010;
        for (int c = 0; c < 3; c++) tick();
        req = '0;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++; if (stats[i*16 +: 16] !== 16'(mstats[i])) begin
                errors++; $display("FAIL stats_count[%0d]: got %0d expected %0d", i, stats[i*16 +: 16], mstats[i]);
            end
        end
        checks++; if (stats[16 +: 16] !== 16'd3) begin errors++; $display("FAIL stats_three: got %0d expected 3", stats[16 +: 16]); end
        req = 4'b0001;
        for (int c = 0; c < 70000; c++) tick();
        req = '0;
        tick();
        checks++; if (stats[0 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h expected ffff", stats[0 +: 16]); end
        checks++; if (stats[16 +: 16] !== 16'(mstats[1])) begin errors++; $display("FAIL stats_other: got %0d expected %0d", stats[16 +: 16], mstats[1]); end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        mptr         = N - 1;
        err_exp      = 1'b0;
        rsp_exp_vld  = '0;
        rsp_exp_data = '0;
        for (int i = 0; i < N; i++) mstats[i] = 0;
        rstn    = 1'b0;
        en      = 1'b0;
        req     = '0;
        req_op1 = '0;
        req_op2 = '0;
        req_cin = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_four();
        test_en_low();
        test_err();
        test_reset_mid();
        test_random();
`ifdef ADDER_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
